// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_pkg                                                            |
// | Shared I2S constants and sequencer state encoding (DAC and ADC side) |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package audio_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_RUN      = 2'd1;
    localparam logic [1:0] ST_STOPPING = 2'd2;

    localparam int DEFAULT_DATA_WIDTH     = 24;
    localparam int DEFAULT_BITS_PER_FRAME = 32;

    // Width of a slot counter covering both channel halves of a frame.
    function automatic int slot_bits(input int bits_per_frame);
        return $clog2(2 * bits_per_frame);
    endfunction

endpackage
`default_nettype wire

// File: rtl/audio_clock_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_clock_divider                                                  |
// | BCLK/LRCK generation, slot counter and one-cycle edge strobes        |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module audio_clock_divider
    import audio_pkg::*;
#(
    parameter int  CLK_DIV        = 4,
    parameter int  BITS_PER_FRAME = DEFAULT_BITS_PER_FRAME,
    localparam int SLOT_W         = slot_bits(BITS_PER_FRAME)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    output logic              bclk,
    output logic              lrck,
    output logic [SLOT_W-1:0] slot,
    output logic              bit_clk_rising_edge,
    output logic              bit_clk_falling_edge,
    output logic              left_right_clk_rising_edge,
    output logic              left_right_clk_falling_edge
);

    localparam int                DIV_W     = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(2 * BITS_PER_FRAME - 1);
    localparam logic [SLOT_W-1:0] SLOT_HALF = SLOT_W'(BITS_PER_FRAME);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [SLOT_W-1:0] slot_q, slot_d;
    logic              bclk_q, bclk_d;
    logic              lrck_q, lrck_d;
    logic              brise_q, brise_d;
    logic              bfall_q, bfall_d;
    logic              lrise_q, lrise_d;
    logic              lfall_q, lfall_d;

    always_comb begin
        div_d   = div_q;
        slot_d  = slot_q;
        bclk_d  = bclk_q;
        lrck_d  = lrck_q;
        brise_d = 1'b0;
        bfall_d = 1'b0;
        lrise_d = 1'b0;
        lfall_d = 1'b0;
        if (!run) begin
            // Parked so the next start gives a rising edge first and slot 0 on the first fall.
            div_d  = '0;
            slot_d = SLOT_LAST;
            bclk_d = 1'b0;
            lrck_d = 1'b0;
        end else if (div_q == DIV_LAST) begin
            div_d  = '0;
            bclk_d = ~bclk_q;
            if (!bclk_q) begin
                brise_d = 1'b1;
            end else begin
                bfall_d = 1'b1;
                slot_d  = (slot_q == SLOT_LAST) ? '0 : slot_q + 1'b1;
                if (slot_d == '0) begin
                    lrck_d  = 1'b0;
                    lfall_d = lrck_q;
                end else if (slot_d == SLOT_HALF) begin
                    lrck_d  = 1'b1;
                    lrise_d = 1'b1;
                end
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            slot_q  <= SLOT_LAST;
            bclk_q  <= 1'b0;
            lrck_q  <= 1'b0;
            brise_q <= 1'b0;
            bfall_q <= 1'b0;
            lrise_q <= 1'b0;
            lfall_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            slot_q  <= slot_d;
            bclk_q  <= bclk_d;
            lrck_q  <= lrck_d;
            brise_q <= brise_d;
            bfall_q <= bfall_d;
            lrise_q <= lrise_d;
            lfall_q <= lfall_d;
        end
    end

    assign bclk                        = bclk_q;
    assign lrck                        = lrck_q;
    assign slot                        = slot_q;
    assign bit_clk_rising_edge         = brise_q;
    assign bit_clk_falling_edge        = bfall_q;
    assign left_right_clk_rising_edge  = lrise_q;
    assign left_right_clk_falling_edge = lfall_q;

endmodule
`default_nettype wire

// File: rtl/audio_i2s_dac_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | audio_i2s_dac_sequencer                                              |
// | Master-mode I2S transmit sequencer with one-entry sample holding reg |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module audio_i2s_dac_sequencer
    import audio_pkg::*;
#(
    parameter int CLK_DIV        = 4,
    parameter int BITS_PER_FRAME = DEFAULT_BITS_PER_FRAME,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] left_data,
    input  logic [DATA_WIDTH-1:0] right_data,
    input  logic                  sample_valid,
    output logic                  sample_ready,
    output logic                  bclk,
    output logic                  lrck,
    output logic                  dacdat,
    output logic                  bit_clk_rising_edge,
    output logic                  bit_clk_falling_edge,
    output logic                  left_right_clk_rising_edge,
    output logic                  left_right_clk_falling_edge,
    output logic                  frame_start,
    output logic                  underflow
);

    localparam int SLOT_W = slot_bits(BITS_PER_FRAME);

    logic [1:0]            state_q, state_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0] act_l_q, act_l_d, act_r_q, act_r_d;

    logic [SLOT_W-1:0]     slot;
    logic                  run;
    logic                  frame_edge;
    logic                  accept;

    assign run = (state_q != ST_IDLE);

    audio_clock_divider #(
        .CLK_DIV        (CLK_DIV),
        .BITS_PER_FRAME (BITS_PER_FRAME)
    ) u_clock_divider (
        .clk                         (clk),
        .reset                       (reset),
        .run                         (run),
        .bclk                        (bclk),
        .lrck                        (lrck),
        .slot                        (slot),
        .bit_clk_rising_edge         (bit_clk_rising_edge),
        .bit_clk_falling_edge        (bit_clk_falling_edge),
        .left_right_clk_rising_edge  (left_right_clk_rising_edge),
        .left_right_clk_falling_edge (left_right_clk_falling_edge)
    );

    // The frame boundary is judged in the cycle bclk falls to slot 0, so a pair
    // offered in that very cycle can still be taken for the new frame.
    assign frame_edge   = bit_clk_falling_edge && (slot == '0);
    assign frame_start  = (state_q == ST_RUN) && frame_edge;
    assign sample_ready = ~hold_full_q;
    assign accept       = sample_valid && sample_ready;
    assign underflow    = frame_start && !hold_full_q && !sample_valid;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (enable) state_d = ST_RUN;
            ST_RUN:      if (!enable) state_d = ST_STOPPING;
            ST_STOPPING: begin
                if (frame_edge) begin
                    state_d = ST_IDLE;
                end else if (enable) begin
                    state_d = ST_RUN;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        act_l_d     = act_l_q;
        act_r_d     = act_r_q;
        if (frame_start) begin
            if (hold_full_q) begin
                act_l_d     = hold_l_q;
                act_r_d     = hold_r_q;
                hold_full_d = 1'b0;
            end else if (sample_valid) begin
                act_l_d = left_data;
                act_r_d = right_data;
            end else begin
                act_l_d = '0;
                act_r_d = '0;
            end
        end else if (accept) begin
            hold_l_d    = left_data;
            hold_r_d    = right_data;
            hold_full_d = 1'b1;
        end
    end

    logic                  first_half;
    logic [SLOT_W-1:0]     pos;
    logic [DATA_WIDTH-1:0] word;
    logic [DATA_WIDTH-1:0] shifted;

    // Active words only change during slot 0, where the output is forced low.
    always_comb begin
        first_half = (slot < SLOT_W'(BITS_PER_FRAME));
        pos        = first_half ? slot : slot - SLOT_W'(BITS_PER_FRAME);
        word       = first_half ? act_l_q : act_r_q;
        shifted    = word >> (SLOT_W'(DATA_WIDTH) - pos);
        dacdat     = run && (pos != '0) && (pos <= SLOT_W'(DATA_WIDTH)) && shifted[0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            act_l_q     <= '0;
            act_r_q     <= '0;
        end else begin
            state_q     <= state_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            act_l_q     <= act_l_d;
            act_r_q     <= act_r_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/audio_i2s_dac_sequencer.md
Name: audio_i2s_dac_sequencer

Overview:
Master-mode I2S transmit sequencer for the audio codec DAC path. It divides the system clock into BCLK and LRCK and serialises left/right sample pairs onto DACDAT. Samples arrive through a one-entry valid/ready holding register. It also exports one-cycle BCLK/LRCK edge strobes so the existing bit-counting and ADC-capture logic can run from the same timing.

Parameters:
CLK_DIV, 4, clk cycles per BCLK half-period (>=2); BCLK period = 2*CLK_DIV clk cycles
BITS_PER_FRAME, 32, BCLK periods per channel half-frame (>= DATA_WIDTH+1)
DATA_WIDTH, 24, sample width per channel, sent MSB first

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  run request; level-sensitive
left_data  in  DATA_WIDTH  left sample, qualified by sample_valid
right_data  in  DATA_WIDTH  right sample, qualified by sample_valid
sample_valid  in  1  sample pair offered
sample_ready  out  1  holding register empty; transfer when valid&&ready
bclk  out  1  serial bit clock
lrck  out  1  word select: 0=left, 1=right
dacdat  out  1  serial data, changes on BCLK falling edge
bit_clk_rising_edge  out  1  1-cycle strobe, same cycle bclk goes 0->1
bit_clk_falling_edge  out  1  1-cycle strobe, same cycle bclk goes 1->0
left_right_clk_rising_edge  out  1  1-cycle strobe, lrck 0->1
left_right_clk_falling_edge  out  1  1-cycle strobe, lrck 1->0
frame_start  out  1  1-cycle strobe, slot 0 of each frame
underflow  out  1  1-cycle strobe, frame started with holding register empty

Behaviour:
- Reset (reset=0, async): state=IDLE. bclk, lrck, dacdat, all strobes and underflow = 0. Holding register empty, so sample_ready=1. Divider=0, slot=2*BITS_PER_FRAME-1.
- FSM states: IDLE, RUN, STOPPING.
  - IDLE -> RUN when enable=1.
  - RUN -> STOPPING when enable=0.
  - STOPPING -> RUN when enable=1 again before the next frame start.
  - STOPPING -> IDLE on the BCLK falling edge that would begin the next frame. That edge emits no frame_start and no underflow. bclk and dacdat are held 0 from then on.
- In IDLE: bclk=0, lrck=0, dacdat=0, no strobes. The holding register still accepts one pair.
- Divider, RUN/STOPPING only: counts 0..CLK_DIV-1. At CLK_DIV-1 it wraps to 0, toggles bclk and fires the matching edge strobe in that same cycle. The first toggle after leaving IDLE is a rising edge, CLK_DIV cycles after entry.
- Slot counter: advances on each falling edge, range 0..2*BITS_PER_FRAME-1, wraps to 0. It is initialised to 2*BITS_PER_FRAME-1, so the first falling edge after entry is slot 0.
- lrck updates on a falling edge:
  - new slot 0 -> lrck=0; left_right_clk_falling_edge fires only if lrck was 1.
  - new slot BITS_PER_FRAME -> lrck=1; left_right_clk_rising_edge fires.
- dacdat updates on a falling edge. With p = slot mod BITS_PER_FRAME:
  - p=0 -> 0 (I2S one-bit delay).
  - 1<=p<=DATA_WIDTH -> bit (DATA_WIDTH-p) of the active left (first half) or right (second half) sample.
  - otherwise 0.
- Frame start (falling edge to slot 0, state RUN): frame_start=1.
  - Holding full: active <= holding; holding emptied.
  - Holding empty and valid&&ready in the same cycle: the incoming pair bypasses straight to active, the holding register stays empty, no underflow.
  - Holding empty and no valid: active <= 0 and underflow=1 for one cycle.
- sample_ready = holding empty. Data is captured on valid&&ready; left/right are latched together.
- The active sample never changes mid-frame.

Decomposition:
- Shared package audio_pkg: FSM state encoding (IDLE/RUN/STOPPING) and the default DATA_WIDTH/BITS_PER_FRAME constants, shared with the ADC-side deserialiser.
- One natural sub-module: audio_clock_divider. It holds the divider, the bclk/lrck registers, the slot counter and the four edge strobes.
- Serialiser, holding register and FSM stay in the top module.

Test Plan:
- Reset, enable=0, then 100 clk -> sample_ready=1; bclk/lrck/dacdat=0; no strobes.
- Load L=24'hA5A5A5, R=24'h5A5A5A, then enable=1 (defaults) -> first rising edge 4 clk after entry; bclk period 8 clk; frame_start at first falling edge.
  - Left slots 1..24 carry A5A5A5 MSB first; slot 0 and slots 25..31 carry 0; lrck rises at slot 32.
  - Right slots 33..56 carry 5A5A5A.
- No second sample supplied -> next frame_start (512 clk later) pulses underflow for 1 clk; dacdat all 0 for that frame.
- sample_valid asserted exactly in the frame_start cycle with holding empty -> pair accepted and transmitted in that frame; underflow=0.
- Deassert enable at slot 40 -> frame completes through slot 63; at the next would-be slot 0 no frame_start fires, state returns to IDLE and bclk stays 0. Re-enable at slot 50 instead -> running continues uninterrupted.
- Assert reset=0 mid-frame (slot 10, bclk=1) -> all outputs 0 immediately, asynchronously. After release the block stays in IDLE until enable=1.
